// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared helpers for the multi-port register file.
//   awCoversDepth : elaboration-time check that an AW-bit address reaches DEPTH
//   addrInRange   : 1 when an address selects an existing register
//   SelW          : width of the per-register write-port select
// ----------------------------------------------------------------------------
package regfile_pkg;

    // Two write ports at most, so a single bit names the winning port.
    localparam int unsigned SelW = 1;

    localparam int unsigned MaxReadPorts  = 4;
    localparam int unsigned MaxWritePorts = 2;

    function automatic bit awCoversDepth(input int unsigned aw, input int unsigned depth);
        if (aw >= 32) begin
            return 1'b1;
        end
        return (32'd1 << aw) >= depth;
    endfunction

    function automatic logic addrInRange(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_wr_decode.sv
// ----------------------------------------------------------------------------
// regfile_wr_decode
// Turns the write and reserve ports into per-register control.
//   writeEn    [NWR]        per-port write enable
//   writeReg   [NWR*AW]     packed write addresses
//   reserveEn               mark reserveReg busy
//   reserveReg [AW]         register to reserve
//   busyQ      [DEPTH]      current busy bits
//   regWe      [DEPTH]      register is written this cycle
//   regSel     [DEPTH][SelW] which write port supplies the data
//   busyD      [DEPTH]      busy next-state
// Out-of-range addresses never match a register index, so they drop out.
// ----------------------------------------------------------------------------
module regfile_wr_decode
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NWR       = 1,
    parameter int unsigned ZERO_REG0 = 1
) (
    input  logic [NWR-1:0]    writeEn,
    input  logic [NWR*AW-1:0] writeReg,
    input  logic              reserveEn,
    input  logic [AW-1:0]     reserveReg,
    input  logic [DEPTH-1:0]  busyQ,
    output logic [DEPTH-1:0]  regWe,
    output logic [SelW-1:0]   regSel [DEPTH],
    output logic [DEPTH-1:0]  busyD
);

    always_comb begin
        regWe = '0;
        busyD = busyQ;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            regSel[r] = '0;
        end

        for (int unsigned r = 0; r < DEPTH; r++) begin
            // Higher-numbered port is visited last, so it wins a collision.
            for (int unsigned p = 0; p < NWR; p++) begin
                if (writeEn[p] && (writeReg[p*AW +: AW] == AW'(r))) begin
                    regWe[r]  = 1'b1;
                    regSel[r] = SelW'(p);
                end
            end

            // A reserve in the same cycle as the write names a newer producer.
            if (reserveEn && (reserveReg == AW'(r))) begin
                busyD[r] = 1'b1;
            end else if (regWe[r]) begin
                busyD[r] = 1'b0;
            end

            if ((ZERO_REG0 != 0) && (r == 0)) begin
                regWe[r] = 1'b0;
                busyD[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with busy (pending-write) tracking.
//   clock            rising-edge clock
//   ctrl_reset       synchronous active-high reset, clears data and busy bits
//   ctrl_writeEn     [NWR]         per-port write enable
//   ctrl_writeReg    [NWR*AW]      packed write addresses
//   data_writeReg    [NWR*WIDTH]   packed write data
//   ctrl_reserveEn   reserve ctrl_reserveReg (set its busy bit)
//   ctrl_reserveReg  [AW]
//   ctrl_readReg     [NRD*AW]      packed read addresses
//   data_readReg     [NRD*WIDTH]   packed read data (combinational)
//   busy_readReg     [NRD]         stored busy bit of each addressed register
//   busy_any         OR of all busy bits
// ----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NRD       = 2,
    parameter int unsigned NWR       = 1,
    parameter int unsigned ZERO_REG0 = 1,
    parameter int unsigned BYPASS    = 0
) (
    input  logic                 clock,
    input  logic                 ctrl_reset,
    input  logic [NWR-1:0]       ctrl_writeEn,
    input  logic [NWR*AW-1:0]    ctrl_writeReg,
    input  logic [NWR*WIDTH-1:0] data_writeReg,
    input  logic                 ctrl_reserveEn,
    input  logic [AW-1:0]        ctrl_reserveReg,
    input  logic [NRD*AW-1:0]    ctrl_readReg,
    output logic [NRD*WIDTH-1:0] data_readReg,
    output logic [NRD-1:0]       busy_readReg,
    output logic                 busy_any
);

    if (!awCoversDepth(AW, DEPTH)) begin : gAwCheck
        $error("regfile_mp: AW cannot address DEPTH registers");
    end
    if ((DEPTH < 2) || (DEPTH > 256)) begin : gDepthCheck
        $error("regfile_mp: DEPTH must be 2..256");
    end
    if ((NRD < 1) || (NRD > MaxReadPorts)) begin : gNrdCheck
        $error("regfile_mp: NRD must be 1..4");
    end
    if ((NWR < 1) || (NWR > MaxWritePorts)) begin : gNwrCheck
        $error("regfile_mp: NWR must be 1..2");
    end

    logic [WIDTH-1:0] regsQ [DEPTH];
    logic [WIDTH-1:0] regsD [DEPTH];
    logic [DEPTH-1:0] busyQ;
    logic [DEPTH-1:0] busyD;
    logic [DEPTH-1:0] regWe;
    logic [SelW-1:0]  regSel [DEPTH];
    logic [WIDTH-1:0] wrData [NWR];

    regfile_wr_decode #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .NWR       (NWR),
        .ZERO_REG0 (ZERO_REG0)
    ) uWrDecode (
        .writeEn    (ctrl_writeEn),
        .writeReg   (ctrl_writeReg),
        .reserveEn  (ctrl_reserveEn),
        .reserveReg (ctrl_reserveReg),
        .busyQ      (busyQ),
        .regWe      (regWe),
        .regSel     (regSel),
        .busyD      (busyD)
    );

    always_comb begin
        for (int unsigned p = 0; p < NWR; p++) begin
            wrData[p] = data_writeReg[p*WIDTH +: WIDTH];
        end
    end

    // Storage next-state: the decoder already resolved collisions and reg 0.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            regsD[r] = regsQ[r];
            if (regWe[r]) begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (regSel[r] == SelW'(p)) begin
                        regsD[r] = wrData[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regsQ[r] <= '0;
            end
            busyQ <= '0;
        end else begin
            regsQ <= regsD;
            busyQ <= busyD;
        end
    end

    // Read muxes. Bypass reuses the decoder's per-register write enable and
    // port select, so read forwarding and storage agree on collisions.
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] rdData;
    logic             rdBusy;

    always_comb begin
        data_readReg = '0;
        busy_readReg = '0;
        rdAddr       = '0;
        rdData       = '0;
        rdBusy       = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rdAddr = ctrl_readReg[i*AW +: AW];
            rdData = '0;
            rdBusy = 1'b0;
            if (addrInRange(32'(rdAddr), DEPTH)) begin
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    if (rdAddr == AW'(r)) begin
                        rdData = regsQ[r];
                        rdBusy = busyQ[r];
                        if ((BYPASS != 0) && regWe[r]) begin
                            for (int unsigned p = 0; p < NWR; p++) begin
                                if (regSel[r] == SelW'(p)) begin
                                    rdData = wrData[p];
                                end
                            end
                        end
                    end
                end
            end
            if ((ZERO_REG0 != 0) && (rdAddr == '0)) begin
                rdData = '0;
            end
            data_readReg[i*WIDTH +: WIDTH] = rdData;
            busy_readReg[i]                = rdBusy;
        end
    end

    assign busy_any = |busyQ;

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// dutA: default configuration (32x32, 2 read, 1 write, zero reg 0, no bypass).
// dutB: DEPTH=20, 3 read, 2 write, reg 0 ordinary, bypass on.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// following falling edge.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // dutA signals
    logic        aRst;
    logic [0:0]  aWe;
    logic [4:0]  aWa;
    logic [31:0] aWd;
    logic        aRsvEn;
    logic [4:0]  aRsvReg;
    logic [9:0]  aRd;
    logic [63:0] aData;
    logic [1:0]  aBusy;
    logic        aAny;

    // dutB signals
    logic        bRst;
    logic [1:0]  bWe;
    logic [9:0]  bWa;
    logic [63:0] bWd;
    logic        bRsvEn;
    logic [4:0]  bRsvReg;
    logic [14:0] bRd;
    logic [95:0] bData;
    logic [2:0]  bBusy;
    logic        bAny;

    regfile_mp dutA (
        .clock           (clk),
        .ctrl_reset      (aRst),
        .ctrl_writeEn    (aWe),
        .ctrl_writeReg   (aWa),
        .data_writeReg   (aWd),
        .ctrl_reserveEn  (aRsvEn),
        .ctrl_reserveReg (aRsvReg),
        .ctrl_readReg    (aRd),
        .data_readReg    (aData),
        .busy_readReg    (aBusy),
        .busy_any        (aAny)
    );

    regfile_mp #(
        .WIDTH     (32),
        .DEPTH     (20),
        .AW        (5),
        .NRD       (3),
        .NWR       (2),
        .ZERO_REG0 (0),
        .BYPASS    (1)
    ) dutB (
        .clock           (clk),
        .ctrl_reset      (bRst),
        .ctrl_writeEn    (bWe),
        .ctrl_writeReg   (bWa),
        .data_writeReg   (bWd),
        .ctrl_reserveEn  (bRsvEn),
        .ctrl_reserveReg (bRsvReg),
        .ctrl_readReg    (bRd),
        .data_readReg    (bData),
        .busy_readReg    (bBusy),
        .busy_any        (bAny)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  rr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ea;
    } vecA_t;

    vecA_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bChk(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [2:0] eb, input logic ea);
        @(negedge clk);
        chk({tag, ".d0"}, bData[31:0], e0);
        chk({tag, ".d1"}, bData[63:32], e1);
        chk({tag, ".d2"}, bData[95:64], e2);
        chk({tag, ".busy"}, {29'd0, bBusy}, {29'd0, eb});
        chk({tag, ".any"}, {31'd0, bAny}, {31'd0, ea});
    endtask

    initial begin
        aRst = 1'b1; aWe = '0; aWa = '0; aWd = '0; aRsvEn = 1'b0; aRsvReg = '0; aRd = '0;
        bRst = 1'b1; bWe = '0; bWa = '0; bWd = '0; bRsvEn = 1'b0; bRsvReg = '0; bRd = '0;

        // Scoreboard / bypass=0 vectors for dutA, expected outputs before the edge.
        //            we    wa     wd            rsv   rr     ra0    ra1    e0            e1            eb     ea
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd5, 5'd5, 32'h0000DEB2, 32'h0000DEB2, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'h0000DEB2, 32'h0000DEB2, 2'b11, 1'b1};
        vecs[2]  = '{1'b1, 5'd5, 32'h55,       1'b0, 5'd0, 5'd5, 5'd5, 32'h0000DEB2, 32'h0000DEB2, 2'b11, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'h55,       32'h55,       2'b00, 1'b0};
        vecs[4]  = '{1'b1, 5'd5, 32'h66,       1'b1, 5'd5, 5'd5, 5'd5, 32'h55,       32'h55,       2'b00, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'h66,       32'h66,       2'b11, 1'b1};
        vecs[6]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd5, 32'h0,        32'h66,       2'b10, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h0000DEB4, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7, 32'h0000DEB4, 32'h0000DEB4, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 5'd5, 32'h77,       1'b0, 5'd0, 5'd7, 5'd5, 32'h12345678, 32'h66,       2'b10, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'h77,       32'h12345678, 2'b00, 1'b0};

        // ---------------- dutA: reset held two cycles ----------------
        tick();
        tick();
        aRst = 1'b0;
        aRd  = {5'd1, 5'd0};
        @(negedge clk);
        chk("a.reset.d0", aData[31:0], 32'h0);
        chk("a.reset.d1", aData[63:32], 32'h0);
        chk("a.reset.busy", {30'd0, aBusy}, 32'h0);
        chk("a.reset.any", {31'd0, aAny}, 32'h0);

        // Write/read sweep over every register.
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp;
            tick();
            aWe = 1'b1;
            aWa = 5'(i);
            aWd = 32'h0000DEAD + 32'(i);
            tick();
            aWe = 1'b0;
            aRd = {5'(i), 5'(i)};
            exp = (i == 0) ? 32'h0 : 32'h0000DEAD + 32'(i);
            @(negedge clk);
            chk($sformatf("a.sweep%0d.d0", i), aData[31:0], exp);
            chk($sformatf("a.sweep%0d.d1", i), aData[63:32], exp);
        end

        // Table: busy scoreboard, zero register, no-bypass latency.
        for (int k = 0; k < 11; k++) begin
            tick();
            aWe     = vecs[k].we;
            aWa     = vecs[k].wa;
            aWd     = vecs[k].wd;
            aRsvEn  = vecs[k].rsv;
            aRsvReg = vecs[k].rr;
            aRd     = {vecs[k].ra1, vecs[k].ra0};
            @(negedge clk);
            chk($sformatf("a.row%0d.d0", k), aData[31:0], vecs[k].e0);
            chk($sformatf("a.row%0d.d1", k), aData[63:32], vecs[k].e1);
            chk($sformatf("a.row%0d.busy", k), {30'd0, aBusy}, {30'd0, vecs[k].eb});
            chk($sformatf("a.row%0d.any", k), {31'd0, aAny}, {31'd0, vecs[k].ea});
        end

        // Reset dominates a same-cycle write and reserve.
        tick();
        aRst    = 1'b1;
        aWe     = 1'b1;
        aWa     = 5'd9;
        aWd     = 32'hFFFF_FFFF;
        aRsvEn  = 1'b1;
        aRsvReg = 5'd9;
        tick();
        aRst   = 1'b0;
        aWe    = 1'b0;
        aRsvEn = 1'b0;
        aRd    = {5'd7, 5'd9};
        @(negedge clk);
        chk("a.midreset.d0", aData[31:0], 32'h0);
        chk("a.midreset.d1", aData[63:32], 32'h0);
        chk("a.midreset.busy", {30'd0, aBusy}, 32'h0);
        chk("a.midreset.any", {31'd0, aAny}, 32'h0);

        // ---------------- dutB ----------------
        tick();
        bRst = 1'b1;
        tick();
        tick();
        bRst = 1'b0;
        bRd  = {5'd2, 5'd1, 5'd0};
        bChk("b.reset", 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);

        // Write reg0 (ordinary register here), bypassed to all ports.
        tick();
        bWe = 2'b01; bWa = {5'd0, 5'd0}; bWd = {32'h0, 32'hCAFEF00D};
        bRd = {5'd0, 5'd0, 5'd0};
        bChk("b.reg0byp", 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 1'b0);
        tick();
        bWe = 2'b00;
        bChk("b.reg0", 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 1'b0);

        // Same-cycle bypass of reg7.
        tick();
        bWe = 2'b01; bWa = {5'd0, 5'd7}; bWd = {32'h0, 32'h12345678};
        bRd = {5'd0, 5'd0, 5'd7};
        bChk("b.byp7", 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 1'b0);

        // Collision on reg3: port 1 wins for bypass and storage.
        tick();
        bWe = 2'b11; bWa = {5'd3, 5'd3}; bWd = {32'h0000BBBB, 32'hAAAA0000};
        bRd = {5'd7, 5'd3, 5'd3};
        bChk("b.collbyp", 32'h0000BBBB, 32'h0000BBBB, 32'h12345678, 3'b000, 1'b0);
        tick();
        bWe = 2'b00;
        bRd = {5'd0, 5'd3, 5'd3};
        bChk("b.coll", 32'h0000BBBB, 32'h0000BBBB, 32'hCAFEF00D, 3'b000, 1'b0);

        // Reserve and write reg4 together; out-of-range write to 25.
        tick();
        bRsvEn = 1'b1; bRsvReg = 5'd4;
        bWe = 2'b11; bWa = {5'd4, 5'd25}; bWd = {32'h44, 32'hDEADBEEF};
        bRd = {5'd25, 5'd4, 5'd25};
        bChk("b.rsvwr", 32'h0, 32'h44, 32'h0, 3'b000, 1'b0);

        // reg4 stays busy; reserve of out-of-range 25 is ignored.
        tick();
        bRsvEn = 1'b1; bRsvReg = 5'd25;
        bWe = 2'b00;
        bRd = {5'd19, 5'd4, 5'd25};
        bChk("b.busy4", 32'h0, 32'h44, 32'h0, 3'b010, 1'b1);

        // Write reg4 clears busy at the edge; busy output is not bypassed.
        tick();
        bRsvEn = 1'b0;
        bWe = 2'b01; bWa = {5'd0, 5'd4}; bWd = {32'h0, 32'h45};
        bRd = {5'd0, 5'd4, 5'd25};
        bChk("b.clr4byp", 32'h0, 32'h45, 32'hCAFEF00D, 3'b010, 1'b1);
        tick();
        bWe = 2'b00;
        bChk("b.clr4", 32'h0, 32'h45, 32'hCAFEF00D, 3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the processor's fixed 32x32, two-read/one-write register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register busy (pending-write) bits, so the pipeline can stall on operands that are not yet written.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (2..256, need not be a power of two)
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG0, 1, 1 = register 0 always reads 0, ignores writes and never becomes busy
- BYPASS, 0, 1 = a same-cycle write is visible on a matching read port

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset  in  1  synchronous, active-high reset
- ctrl_writeEn  in  NWR  per-port write enable
- ctrl_writeReg  in  NWR*AW  write addresses, packed; port p at [p*AW +: AW]
- data_writeReg  in  NWR*WIDTH  write data, packed the same way
- ctrl_reserveEn  in  1  mark a register busy (an instruction has issued that will write it)
- ctrl_reserveReg  in  AW  register to reserve
- ctrl_readReg  in  NRD*AW  read addresses, packed
- data_readReg  out  NRD*WIDTH  read data, packed
- busy_readReg  out  NRD  busy bit of each addressed register
- busy_any  out  1  OR of all busy bits

Behaviour:
- Reset (ctrl_reset=1 at a rising edge):
  - all registers become 0 and all busy bits become 0;
  - reset dominates every write and reserve in that cycle;
  - a reset asserted in the middle of a write sequence discards that write.
- Outputs after reset: data_readReg=0, busy_readReg=0, busy_any=0.
- Writes:
  - take effect at the rising edge where ctrl_writeEn[p]=1;
  - the new value is visible on the reads one cycle later (read-after-write latency 1 with BYPASS=0).
- Reads:
  - combinational from storage, 0-cycle address-to-data;
  - every read port is independent, and any number of ports may address the same register.
- BYPASS=1: if a read address equals an enabled write address in the same cycle, that port returns data_writeReg of the matching write port (subject to the collision and zero rules).
- Write collision (NWR=2, both enabled, same address): port 1 wins. This applies to both storage and bypass.
- Busy bits:
  - set at the edge where ctrl_reserveEn=1;
  - cleared at the edge where any enabled write targets that register;
  - if a reserve and a write hit the same register in the same cycle, the register stays busy, because the reserve represents a newer producer. The write data is still stored.
- ZERO_REG0=1:
  - data_readReg for address 0 is 0, even under bypass;
  - writes and reserves to register 0 are dropped, and busy for register 0 is always 0.
- ZERO_REG0=0: register 0 behaves like any other register.
- Out-of-range address (>= DEPTH): writes and reserves are ignored; reads return 0 with busy=0.
- busy_readReg reflects the stored busy bit only; it is not bypassed.
- No X may propagate from uninitialised storage after the first reset.

Decomposition:
- Shared package regfile_pkg holds:
  - a function that checks that AW can address DEPTH;
  - a function that decodes an address to an in-range flag.
- One natural sub-module, regfile_wr_decode: given the write and reserve ports, it produces per-register write-enable, write-data select and busy next-state. It is reused in the bypass compare.
- Storage and the read muxes stay in the top level.

Test Plan:
- Reset then write/read sweep (defaults): reset held 2 cycles; for i=0..31 write 32'h0000DEAD+i, then read on both ports. Required: reg0 reads 0; every other register i reads 32'h0000DEAD+i on both ports.
- ZERO_REG0=0: write reg0=32'hCAFEF00D, then read. Required: 32'hCAFEF00D on all ports.
- BYPASS=1: write reg7=32'h12345678 while reading reg7 in the same cycle. Required: 32'h12345678 in that same cycle.
  - With BYPASS=0 the same stimulus gives the old value (0) in that cycle and 32'h12345678 in the next.
- NWR=2 collision: port0 writes reg3=32'hAAAA0000 and port1 writes reg3=32'h0000BBBB in the same cycle. Required: reg3 reads 32'h0000BBBB.
- Scoreboard: reserve reg5 → busy_readReg=1 and busy_any=1 next cycle; then write reg5=32'h55 → busy=0 and data 32'h55. Reserve and write reg5 in the same cycle → busy stays 1 and data updates.
- Reset mid-operation: reserve reg9 and write reg9=32'hFFFF_FFFF while ctrl_reset=1. Required: reg9 reads 0, busy 0; an out-of-range read with DEPTH=20 and address 25 returns 0.
